// File: rtl/fifo_rv_thresh.sv
// ----------------------------------------------------------------------------
// fifo_rv_thresh
//   Synchronous ready/valid FIFO with first-word-fall-through read data,
//   registered occupancy count, almost-full / almost-empty threshold flags
//   and optional sticky overflow / underflow error flags.
//
// Parameters
//   DEPTH      number of entries (power of two, >= 2)
//   WIDTH      data bits per entry
//   AF_THRESH  almost_full when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   clk           clock, all state updates on rising edge
//   reset         synchronous active-high reset (highest priority)
//   flush         synchronous discard of all contents (over push/pop)
//   in_valid      write request
//   in_ready      write accepted when high (not full)
//   in_data       write data
//   out_valid     read data available (not empty)
//   out_ready     read acknowledge
//   out_data      oldest entry while out_valid, else zero
//   count         current occupancy, 0..DEPTH
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//
// Build option
//   FIFO_RV_THRESH_ERR_FLAGS_EN  when defined, overflow/underflow are sticky
//                                registered flags; otherwise tied to 0.
// ----------------------------------------------------------------------------
module fifo_rv_thresh #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 32,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Pointers carry one extra wrap bit: equal means empty, differing only
    // in the wrap bit means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    // Handshake outputs come from registered state only, so neither flush
    // nor out_ready reaches in_ready combinationally.
    assign in_ready  = ~full;
    assign out_valid = ~empty;

    assign push = in_valid  & in_ready;
    assign pop  = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + PW'(1);
            end else if (pop && !push) begin
                count_d = count_q - PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; resetting the pointers is enough
    // to discard the contents.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_q[wr_idx] <= in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_data     = out_valid ? mem_q[rd_idx] : '0;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);

`ifdef FIFO_RV_THRESH_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow_d = 1'b1;
            end
            if (out_ready && !out_valid) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rv_thresh.sv
module tb_fifo_rv_thresh;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    fifo_rv_thresh #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .AF_THRESH(AF),
        .AE_THRESH(AE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of words plus two sticky bits.
    logic [WIDTH-1:0] model_q[$];
    logic             m_ovf;
    logic             m_udf;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = model_q.size();
        chk("count",        32'(count),        32'(n));
        chk("in_ready",     32'(in_ready),     32'(n != DEPTH));
        chk("out_valid",    32'(out_valid),    32'(n != 0));
        chk("out_data",     32'(out_data),     (n != 0) ? 32'(model_q[0]) : 32'd0);
        chk("almost_full",  32'(almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input logic vin, input logic [WIDTH-1:0] din,
                        input logic rdy, input logic fl, input logic rst);
        int  n;
        logic do_push, do_pop;
        reset     = rst;
        flush     = fl;
        in_valid  = vin;
        in_data   = din;
        out_ready = rdy;
        n = model_q.size();
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            do_push = vin && (n < DEPTH);
            do_pop  = rdy && (n > 0);
`ifdef FIFO_RV_THRESH_ERR_FLAGS_EN
            if (vin && n == DEPTH) m_ovf = 1'b1;
            if (rdy && n == 0)     m_udf = 1'b1;
`endif
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(din);
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        int bias;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Fill to full with out_ready low
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);

        // Write while full with a pop in the same cycle: write dropped
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Down to two entries, then simultaneous push/pop across pointer wraps
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, 1'b0);

        // Drain, then one extra read on empty
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Build to three, then flush with push and pop asserted
        step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h63, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h64, 1'b1, 1'b1, 1'b0);

        // Build to two, then reset together with flush and push
        step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h73, 1'b0, 1'b1, 1'b1);

        // Randomized traffic with phases biased toward full and toward empty
        for (int i = 0; i < 600; i++) begin
            bias = ((i / 100) % 2 == 0) ? 3 : 1;
            d = 8'($urandom);
            step(($urandom_range(0, 3) < bias) ? 1'b1 : 1'b0, d,
                 ($urandom_range(0, 3) < (4 - bias)) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
